// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the control unit, main memory and benches:
//   access-size codes carried on typeData, the RW read/write polarity and
//   the memory handshake FSM state type.
//   No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [1:0] TYPE_BYTE = 2'b00;
   localparam logic [1:0] TYPE_HALF = 2'b01;
   localparam logic [1:0] TYPE_WORD = 2'b10;
   localparam logic [1:0] TYPE_ILL  = 2'b11;

   localparam logic       RW_READ   = 1'b1;
   localparam logic       RW_WRITE  = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } mem_state_t;

endpackage

// File: rtl/mem_lane_steer.sv
// ---------------------------------------------------------------------------
// mem_lane_steer
//   Combinational lane steering for the big-endian byte memory.
//   Lane 0 is the byte at the access address and sits in bits [31:24] of
//   the raw/lane buses; lane 3 is address+3 in bits [7:0].
//   Ports:
//     i_type     access size (byte/half/word/illegal)
//     i_addr_lo  low two address bits, used for the alignment test
//     i_wdata    right-justified write data
//     i_raw      bytes mem[a..a+3] concatenated big-endian
//     o_be       lane write enables, bit 3 = lane 0
//     o_wlanes   write data placed on the lanes
//     o_rdata    read data, zero-extended and right-justified
//     o_aligned  address is aligned for the requested size
//     o_illegal  size code is the reserved value
// ---------------------------------------------------------------------------
module mem_lane_steer
   import cpu_pkg::*;
(
   input  logic [1:0]  i_type,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_raw,
   output logic [3:0]  o_be,
   output logic [31:0] o_wlanes,
   output logic [31:0] o_rdata,
   output logic        o_aligned,
   output logic        o_illegal
);

   always_comb begin
      o_be      = '0;
      o_wlanes  = '0;
      o_rdata   = '0;
      o_aligned = 1'b1;
      o_illegal = 1'b0;
      case (i_type)
         TYPE_BYTE: begin
            o_be     = 4'b1000;
            o_wlanes = {i_wdata[7:0], 24'h000000};
            o_rdata  = {24'h000000, i_raw[31:24]};
         end
         TYPE_HALF: begin
            o_aligned = ~i_addr_lo[0];
            o_be      = 4'b1100;
            o_wlanes  = {i_wdata[15:0], 16'h0000};
            o_rdata   = {16'h0000, i_raw[31:16]};
         end
         TYPE_WORD: begin
            o_aligned = (i_addr_lo == 2'b00);
            o_be      = 4'b1111;
            o_wlanes  = i_wdata;
            o_rdata   = i_raw;
         end
         TYPE_ILL: begin
            o_illegal = 1'b1;
         end
         default: begin
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ram_mov_moc.sv
// ---------------------------------------------------------------------------
// ram_mov_moc
//   Byte-addressable main memory with a MOV/MOC four-phase handshake,
//   programmable wait states and error reporting for misaligned or
//   illegal-size accesses. Big-endian byte/halfword/word accesses.
//   Ports:
//     CLK       clock, rising edge
//     CLR       synchronous active-high reset
//     MOV       memory operation valid, held until MOC is seen
//     RW        1 = read, 0 = write
//     typeData  00 byte, 01 halfword, 10 word, 11 illegal
//     address   byte address
//     DaIn      right-justified write data
//     DaOut     zero-extended, right-justified read data
//     MOC       memory operation complete
//     ERR       access rejected; valid while MOC=1
// ---------------------------------------------------------------------------
module ram_mov_moc
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              MOV,
   input  logic              RW,
   input  logic [1:0]        typeData,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] DaIn,
   output logic [DATA_W-1:0] DaOut,
   output logic              MOC,
   output logic              ERR
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   // Storage keeps this exact name so benches can preload it by hierarchy.
   logic [7:0] mem [0:2**ADDR_W-1];

   mem_state_t        r_state, w_next_state;
   logic [CNT_W-1:0]  r_cnt, w_next_cnt;

   logic [ADDR_W-1:0] r_addr;
   logic              r_rw;
   logic [1:0]        r_type;
   logic [DATA_W-1:0] r_din;

   logic              r_moc;
   logic              r_err;
   logic [DATA_W-1:0] r_dout;

   logic              w_latch;
   logic              w_access;
   logic              w_clear;
   logic [31:0]       w_raw;
   logic [31:0]       w_wlanes;
   logic [31:0]       w_rdata;
   logic [3:0]        w_be;
   logic              w_aligned;
   logic              w_illegal;
   logic              w_err;
   logic              w_wr_en;

   assign w_raw = {mem[r_addr],
                   mem[r_addr + ADDR_W'(1)],
                   mem[r_addr + ADDR_W'(2)],
                   mem[r_addr + ADDR_W'(3)]};

   mem_lane_steer u_steer (
      .i_type    (r_type),
      .i_addr_lo (r_addr[1:0]),
      .i_wdata   (r_din),
      .i_raw     (w_raw),
      .o_be      (w_be),
      .o_wlanes  (w_wlanes),
      .o_rdata   (w_rdata),
      .o_aligned (w_aligned),
      .o_illegal (w_illegal)
   );

   assign w_err = w_illegal | ~w_aligned;

   // The access is performed on the first edge spent in DONE (MOC still
   // low there), which gives MOC WAIT_CYCLES+1 edges after MOV is sampled
   // and lets a MOV that dropped during WAIT still complete the access.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_latch      = 1'b0;
      w_access     = 1'b0;
      w_clear      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (MOV) begin
               w_latch = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_WAIT;
                  w_next_cnt   = CNT_W'(WAIT_CYCLES - 1);
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_cnt = r_cnt - CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (!r_moc) begin
               w_access = 1'b1;
            end else if (!MOV) begin
               w_next_state = ST_IDLE;
               w_clear      = 1'b1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_moc   <= 1'b0;
         r_err   <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_access) begin
            r_moc <= 1'b1;
            r_err <= w_err;
            if (!w_err && (r_rw == RW_READ)) begin
               r_dout <= DATA_W'(w_rdata);
            end
         end else if (w_clear) begin
            r_moc <= 1'b0;
            r_err <= 1'b0;
         end
      end
   end

   // Request capture; inputs are ignored for the rest of the operation.
   always_ff @(posedge CLK) begin
      if (w_latch) begin
         r_addr <= address;
         r_rw   <= RW;
         r_type <= typeData;
         r_din  <= DaIn;
      end
   end

   assign w_wr_en = w_access && !w_err && (r_rw == RW_WRITE) && !CLR;

   always_ff @(posedge CLK) begin
      if (w_wr_en) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (w_be[3-i]) begin
               mem[r_addr + ADDR_W'(i)] <= w_wlanes[31-8*i -: 8];
            end
         end
      end
   end

   assign DaOut = r_dout;
   assign MOC   = r_moc;
   assign ERR   = r_err;

endmodule

// File: tb/tb_ram_mov_moc.sv
// ---------------------------------------------------------------------------
// tb_ram_mov_moc
//   Scoreboard bench for ram_mov_moc: one instance with two wait states and
//   one with none. Each issued operation pushes its expected completion
//   (latency, ERR, DaOut) into a per-instance queue; monitors pop on every
//   MOC rising edge. A byte-array reference memory tracks expected contents.
// ---------------------------------------------------------------------------
module tb_ram_mov_moc;
   import cpu_pkg::*;

   localparam int WC0 = 2;
   localparam int WC1 = 0;

   typedef struct {
      logic        err;
      logic [31:0] dout;
      int          issue;
   } exp_t;

   logic        CLK = 1'b0;
   logic        CLR;
   logic        mov0, rw0, mov1, rw1;
   logic [1:0]  td0, td1;
   logic [7:0]  ad0, ad1;
   logic [31:0] di0, di1;
   logic [31:0] do0, do1;
   logic        moc0, err0, moc1, err1;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [7:0]  ref_mem [2][256];
   logic [31:0] ref_dout [2];

   ram_mov_moc #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(WC0)) dut (
      .CLK(CLK), .CLR(CLR), .MOV(mov0), .RW(rw0), .typeData(td0),
      .address(ad0), .DaIn(di0), .DaOut(do0), .MOC(moc0), .ERR(err0)
   );

   ram_mov_moc #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(WC1)) dut0 (
      .CLK(CLK), .CLR(CLR), .MOV(mov1), .RW(rw1), .typeData(td1),
      .address(ad1), .DaIn(di1), .DaOut(do1), .MOC(moc1), .ERR(err1)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int inst, input logic m, input logic r, input logic [1:0] t,
                        input logic [7:0] a, input logic [31:0] d);
      if (inst == 0) begin mov0 = m; rw0 = r; td0 = t; ad0 = a; di0 = d; end
      else           begin mov1 = m; rw1 = r; td1 = t; ad1 = a; di1 = d; end
   endtask

   task automatic sample(input int inst, output logic m, output logic e, output logic [31:0] o);
      if (inst == 0) begin m = moc0; e = err0; o = do0; end
      else           begin m = moc1; e = err1; o = do1; end
   endtask

   function automatic logic [7:0] dut_mem(input int inst, input int i);
      return (inst == 0) ? dut.mem[i] : dut0.mem[i];
   endfunction

   // Reference: size in bytes, alignment by modulo, big-endian byte order.
   function automatic exp_t model(input int inst, input logic r, input logic [1:0] t,
                                  input logic [7:0] a, input logic [31:0] d);
      exp_t e;
      int   n;
      int   ai;
      n  = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : (t == 2'd2) ? 4 : 0;
      ai = int'(a);
      e.err = (n == 0) || ((ai % n) != 0);
      if (!e.err) begin
         if (r) begin
            ref_dout[inst] = '0;
            for (int k = 0; k < n; k++)
               ref_dout[inst] = (ref_dout[inst] << 8) | 32'(ref_mem[inst][ai+k]);
         end else begin
            for (int k = 0; k < n; k++)
               ref_mem[inst][ai+k] = d[8*(n-1-k) +: 8];
         end
      end
      e.dout  = ref_dout[inst];
      e.issue = 0;
      return e;
   endfunction

   // Monitors: compare every completion against the oldest expectation.
   logic pm0 = 1'b0;
   logic pm1 = 1'b0;
   exp_t me0, me1;

   always @(negedge CLK) begin
      if (moc0 && !pm0) begin
         if (q0.size() == 0) begin
            check("moc0_unexpected", 32'(moc0), 32'd0);
         end else begin
            me0 = q0.pop_front();
            check("lat0", 32'(cyc - me0.issue), 32'(WC0 + 1));
            check("err0", 32'(err0), 32'(me0.err));
            check("dout0", do0, me0.dout);
         end
      end
      pm0 = moc0;
   end

   always @(negedge CLK) begin
      if (moc1 && !pm1) begin
         if (q1.size() == 0) begin
            check("moc1_unexpected", 32'(moc1), 32'd0);
         end else begin
            me1 = q1.pop_front();
            check("lat1", 32'(cyc - me1.issue), 32'(WC1 + 1));
            check("err1", 32'(err1), 32'(me1.err));
            check("dout1", do1, me1.dout);
         end
      end
      pm1 = moc1;
   end

   // One full handshake. Inputs other than MOV are scrambled while waiting
   // to show the request was captured when MOV was sampled.
   task automatic do_op(input int inst, input logic r, input logic [1:0] t, input logic [7:0] a,
                        input logic [31:0] d, input int hold, input bit early);
      exp_t        e;
      logic        m, er;
      logic [31:0] o;
      logic        cur_mov;
      bit          seen;
      @(negedge CLK);
      drive(inst, 1'b1, r, t, a, d);
      cur_mov = 1'b1;
      e = model(inst, r, t, a, d);
      e.issue = cyc + 1;
      if (inst == 0) q0.push_back(e); else q1.push_back(e);
      if (early) begin
         @(negedge CLK);
         cur_mov = 1'b0;
         drive(inst, 1'b0, r, t, a, d);
      end
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge CLK);
         sample(inst, m, er, o);
         if (m) seen = 1'b1;
         else drive(inst, cur_mov, 1'($urandom), 2'($urandom), 8'($urandom), $urandom);
      end
      check("moc_seen", 32'(seen), 32'd1);
      for (int h = 0; h < hold; h++) begin
         @(negedge CLK);
         sample(inst, m, er, o);
         check("hold_moc", 32'(m), 32'd1);
         check("hold_err", 32'(er), 32'(e.err));
         check("hold_dout", o, e.dout);
      end
      drive(inst, 1'b0, 1'($urandom), 2'($urandom), 8'($urandom), $urandom);
      @(negedge CLK);
      sample(inst, m, er, o);
      check("release_moc", 32'(m), 32'd0);
      check("release_err", 32'(er), 32'd0);
      check("release_dout", o, e.dout);
   endtask

   task automatic rand_op(input int inst);
      logic [1:0] t;
      logic [7:0] a;
      t = 2'($urandom_range(0, 3));
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 7) begin
         if (t == 2'd1) a[0] = 1'b0;
         if (t == 2'd2) a[1:0] = 2'b00;
      end
      do_op(inst, 1'($urandom), t, a, $urandom, $urandom_range(0, 2), 1'b0);
   endtask

   initial begin
      logic        m, er;
      logic [31:0] o;
      logic [7:0]  b;
      logic [31:0] exp_half;

      CLR = 1'b1;
      drive(0, 1'b0, 1'b0, 2'b00, 8'h00, 32'h0);
      drive(1, 1'b0, 1'b0, 2'b00, 8'h00, 32'h0);
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom);
         dut.mem[i] = b;  ref_mem[0][i] = b;
         b = 8'($urandom);
         dut0.mem[i] = b; ref_mem[1][i] = b;
      end
      dut.mem[0] = 8'h11; dut.mem[1] = 8'h22; dut.mem[2] = 8'h33; dut.mem[3] = 8'h44;
      ref_mem[0][0] = 8'h11; ref_mem[0][1] = 8'h22; ref_mem[0][2] = 8'h33; ref_mem[0][3] = 8'h44;
      ref_dout[0] = '0;
      ref_dout[1] = '0;

      repeat (2) @(negedge CLK);
      check("rst_moc0", 32'(moc0), 32'd0);
      check("rst_err0", 32'(err0), 32'd0);
      check("rst_dout0", do0, 32'd0);
      check("rst_moc1", 32'(moc1), 32'd0);
      check("rst_dout1", do1, 32'd0);
      CLR = 1'b0;

      // Word read of preloaded bytes.
      do_op(0, RW_READ, TYPE_WORD, 8'd0, 32'h0, 0, 1'b0);
      check("t1_word_read", do0, 32'h11223344);

      // Byte write then halfword read covering it.
      do_op(0, RW_WRITE, TYPE_BYTE, 8'd5, 32'hDEADBEA5, 0, 1'b0);
      check("t2_mem5", 32'(dut_mem(0, 5)), 32'h000000A5);
      exp_half = {16'h0000, ref_mem[0][4], 8'hA5};
      do_op(0, RW_READ, TYPE_HALF, 8'd4, 32'h0, 0, 1'b0);
      check("t2_half_read", do0, exp_half);

      // Misaligned word read and write.
      do_op(0, RW_READ, TYPE_WORD, 8'd2, 32'h0, 1, 1'b0);
      check("t3_dout_kept", do0, exp_half);
      do_op(0, RW_WRITE, TYPE_WORD, 8'd1, 32'hCAFEF00D, 0, 1'b0);
      for (int k = 1; k <= 4; k++)
         check("t3_mem_kept", 32'(dut_mem(0, k)), 32'(ref_mem[0][k]));

      // Illegal size with MOV held five cycles in DONE.
      do_op(0, RW_READ, TYPE_ILL, 8'd8, 32'h0, 5, 1'b0);

      // MOV withdrawn during WAIT still completes.
      do_op(0, RW_READ, TYPE_WORD, 8'd16, 32'h0, 0, 1'b1);
      do_op(0, RW_WRITE, TYPE_HALF, 8'd20, 32'h0000BEEF, 0, 1'b1);

      // Reset while waiting abandons the write.
      @(negedge CLK);
      drive(0, 1'b1, RW_WRITE, TYPE_WORD, 8'd8, 32'h12345678);
      @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      CLR = 1'b0;
      drive(0, 1'b0, 1'b0, 2'b00, 8'h00, 32'h0);
      ref_dout[0] = '0;
      ref_dout[1] = '0;
      check("t5_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
      check("t5_dout_reset", do0, 32'd0);
      for (int n = 0; n < 5; n++) begin
         sample(0, m, er, o);
         check("t5_no_moc", 32'(m), 32'd0);
         @(negedge CLK);
      end
      for (int k = 8; k < 12; k++)
         check("t5_mem_kept", 32'(dut_mem(0, k)), 32'(ref_mem[0][k]));

      // Zero-wait instance at the top of memory.
      do_op(1, RW_READ, TYPE_WORD, 8'd252, 32'h0, 1, 1'b0);
      check("t6_top_word", do1, {ref_mem[1][252], ref_mem[1][253], ref_mem[1][254], ref_mem[1][255]});

      for (int i = 0; i < 40; i++) rand_op(0);
      for (int i = 0; i < 15; i++) rand_op(1);

      repeat (3) @(negedge CLK);
      check("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
      for (int i = 0; i < 256; i++) begin
         check("final_mem0", 32'(dut_mem(0, i)), 32'(ref_mem[0][i]));
         check("final_mem1", 32'(dut_mem(1, i)), 32'(ref_mem[1][i]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
